uart_bus_arbiter: RTL and testbench

Shares the `uart_top` register bus (address/write_data/we/re/read_data) between `N` requesters with round-robin fairness, one register transaction at a time. A frame-guard timer holds back TX_DATA writes until the previous character has had time to shift out, because `uart_top` exposes no busy flag. The block sits between the requesters (CPU port, DMA, debug) and `uart_top`. Its bus outputs connect directly to `uart_top`'s `address`/`write_data`/`we`/`re`/`read_data`.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rr_arbiter.sv | 32 +++
 rtl/uart_bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_uart_bus_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the uart_top register-bus arbiter: register map,
// arbiter FSM states and frame-guard helpers.
package uart_pkg;

  localparam logic [1:0] BAUD_DATA = 2'd0;
  localparam logic [1:0] ENABLE    = 2'd1;
  localparam logic [1:0] TX_DATA   = 2'd2;
  localparam logic [1:0] RX_DATA   = 2'd3;

  localparam int FRAME_BITS_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_t;

  // Cycles one character occupies the line: divisor times bit times per frame.
  function automatic logic [35:0] guard_cycles(input logic [31:0] shadow,
                                               input int          frame_bits);
    return {4'd0, shadow} * 36'(frame_bits);
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or after
// last+1 (mod N), returned one-hot.
module uart_rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         i_elig,
  input  logic [$clog2(N)-1:0] i_last,
  output logic [N-1:0]         o_gnt
);

  logic [N-1:0] w_rot;
  logic         w_found;
  int           w_pick;

  always_comb begin
    // Rotate so bit 0 is requester last+1; the lowest set bit then wins.
    w_rot   = N'({i_elig, i_elig} >> (int'(i_last) + 1));
    w_found = 1'b0;
    w_pick  = 0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_pick  = k;
      end
    end
    o_gnt = '0;
    for (int i = 0; i < N; i++) begin
      o_gnt[i] = w_found && (i == ((w_pick + int'(i_last) + 1) % N));
    end
  end

endmodule

// File: rtl/uart_bus_arbiter.sv
// Round-robin sharing of the uart_top register bus, one transaction per
// IDLE->ISSUE->RESP pass. Define UART_ARB_TX_GUARD_EN for the TX_DATA frame guard.
module uart_bus_arbiter
  import uart_pkg::*;
#(
  parameter int N          = 2,
  parameter int FRAME_BITS = FRAME_BITS_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [2*N-1:0]  req_address,
  input  logic [32*N-1:0] req_write_data,
  input  logic [N-1:0]    req_we,
  input  logic [N-1:0]    req_re,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    done,
  output logic [7:0]      rdata,
  output logic [1:0]      uart_address,
  output logic [31:0]     uart_write_data,
  output logic            uart_we,
  output logic            uart_re,
  input  logic [7:0]      uart_read_data
);

  localparam int IW = $clog2(N);

  if (N < 2 || N > 8 || FRAME_BITS < 1 || FRAME_BITS > 15) begin : g_bad_param
    $error("uart_bus_arbiter: N must be 2..8 and FRAME_BITS 1..15");
  end

  arb_state_t    r_state;
  logic [IW-1:0] r_last;
  logic [IW-1:0] r_idx;
  logic          r_is_rd;
  logic [N-1:0]  r_gnt;
  logic [N-1:0]  r_done;
  logic [7:0]    r_rdata;
  logic [1:0]    r_uart_address;
  logic [31:0]   r_uart_write_data;
  logic          r_uart_we;
  logic          r_uart_re;

  logic [N-1:0]  w_elig;
  logic [N-1:0]  w_gnt;
  logic [IW-1:0] w_sel_idx;
  logic [1:0]    w_sel_addr;
  logic [31:0]   w_sel_wdata;
  logic          w_sel_we;
  logic          w_sel_re;
  logic          w_start;

`ifdef UART_ARB_TX_GUARD_EN
  logic [31:0] r_shadow;
  logic [35:0] r_guard;
`endif

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_elig[i] = req[i];
`ifdef UART_ARB_TX_GUARD_EN
      // Only TX_DATA writes wait for the previous character to leave the line.
      if (r_guard != '0 && req_we[i] && req_address[2*i +: 2] == TX_DATA) begin
        w_elig[i] = 1'b0;
      end
`endif
    end
  end

  uart_rr_arbiter #(.N(N)) u_rr (
    .i_elig (w_elig),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  always_comb begin
    w_sel_idx   = '0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_we    = 1'b0;
    w_sel_re    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt[i]) begin
        w_sel_idx   = IW'(i);
        w_sel_addr  = req_address[2*i +: 2];
        w_sel_wdata = req_write_data[32*i +: 32];
        w_sel_we    = req_we[i];
        w_sel_re    = req_re[i];
      end
    end
  end

  assign w_start = (r_state == IDLE) && (w_gnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= IDLE;
      r_last            <= IW'(N - 1);
      r_idx             <= '0;
      r_is_rd           <= 1'b0;
      r_gnt             <= '0;
      r_done            <= '0;
      r_rdata           <= '0;
      r_uart_address    <= '0;
      r_uart_write_data <= '0;
      r_uart_we         <= 1'b0;
      r_uart_re         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_gnt             <= w_gnt;
            r_idx             <= w_sel_idx;
            r_uart_address    <= w_sel_addr;
            r_uart_write_data <= w_sel_wdata;
            // Write wins when both qualifiers are set; neither means a no-op.
            r_uart_we         <= w_sel_we;
            r_uart_re         <= !w_sel_we && w_sel_re;
            r_is_rd           <= !w_sel_we && w_sel_re;
            r_state           <= ISSUE;
          end
        end
        ISSUE: begin
          r_uart_we <= 1'b0;
          r_uart_re <= 1'b0;
          r_gnt     <= '0;
          r_done    <= r_gnt;
          if (r_is_rd) begin
            r_rdata <= uart_read_data;
          end
          r_last  <= r_idx;
          r_state <= RESP;
        end
        RESP: begin
          r_done            <= '0;
          r_uart_address    <= '0;
          r_uart_write_data <= '0;
          r_state           <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef UART_ARB_TX_GUARD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_guard  <= '0;
    end else begin
      if (w_start && w_sel_we && w_sel_addr == BAUD_DATA) begin
        r_shadow <= w_sel_wdata;
      end
      // A TX_DATA grant implies the guard is already zero, so load never collides.
      if (w_start && w_sel_we && w_sel_addr == TX_DATA) begin
        r_guard <= guard_cycles(r_shadow, FRAME_BITS);
      end else if (r_guard != '0) begin
        r_guard <= r_guard - 36'd1;
      end
    end
  end
`endif

  assign gnt             = r_gnt;
  assign done            = r_done;
  assign rdata           = r_rdata;
  assign uart_address    = r_uart_address;
  assign uart_write_data = r_uart_write_data;
  assign uart_we         = r_uart_we;
  assign uart_re         = r_uart_re;

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Self-checking bench for uart_bus_arbiter: directed scenarios plus random
// traffic against a transaction-level schedule model.
module tb_uart_bus_arbiter;
  import uart_pkg::*;

  localparam int N  = 2;
  localparam int FB = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [2*N-1:0]  req_address;
  logic [32*N-1:0] req_write_data;
  logic [N-1:0]    req_we;
  logic [N-1:0]    req_re;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic [7:0]      rdata;
  logic [1:0]      uart_address;
  logic [31:0]     uart_write_data;
  logic            uart_we;
  logic            uart_re;
  logic [7:0]      uart_read_data;

  always #5 clk = ~clk;

  uart_bus_arbiter #(.N(N), .FRAME_BITS(FB)) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .req_address     (req_address),
    .req_write_data  (req_write_data),
    .req_we          (req_we),
    .req_re          (req_re),
    .gnt             (gnt),
    .done            (done),
    .rdata           (rdata),
    .uart_address    (uart_address),
    .uart_write_data (uart_write_data),
    .uart_we         (uart_we),
    .uart_re         (uart_re),
    .uart_read_data  (uart_read_data)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit auto_drop = 1'b1;
  bit rand_rd = 1'b0;

  // Reference model: who was granted, when, and when TX_DATA may next issue.
  int          m_last;
  int          m_g_cyc;
  int          m_next_arb;
  int          m_w;
  int          m_kind;   // 0 no-op, 1 write, 2 read
  logic [1:0]  m_addr;
  logic [31:0] m_data;
  logic [7:0]  m_rd;
  longint      m_shadow;
  longint      m_tx_ok;

  int tx_issue[$];
  int en_issue[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit model_eligible(input int i);
    bit e;
    e = req[i];
`ifdef UART_ARB_TX_GUARD_EN
    if (req_we[i] && req_address[2*i +: 2] == TX_DATA && longint'(cyc) < m_tx_ok) e = 1'b0;
`endif
    return e;
  endfunction

  task automatic model_arb();
    int win;
    if (rst) begin
      m_g_cyc    = -10;
      m_next_arb = cyc + 1;
      m_last     = N - 1;
      m_shadow   = 0;
      m_tx_ok    = 0;
      return;
    end
    if (cyc == m_g_cyc) m_rd = uart_read_data;
    if (cyc < m_next_arb) return;
    win = -1;
    for (int k = 1; k <= N; k++) begin
      if (win < 0 && model_eligible((m_last + k) % N)) win = (m_last + k) % N;
    end
    if (win < 0) return;
    m_w        = win;
    m_g_cyc    = cyc + 1;
    m_next_arb = cyc + 3;
    m_last     = win;
    m_addr     = req_address[2*win +: 2];
    m_data     = req_write_data[32*win +: 32];
    m_kind     = req_we[win] ? 1 : (req_re[win] ? 2 : 0);
`ifdef UART_ARB_TX_GUARD_EN
    if (m_kind == 1 && m_addr == BAUD_DATA) m_shadow = longint'(m_data);
    if (m_kind == 1 && m_addr == TX_DATA) m_tx_ok = longint'(cyc + 1) + m_shadow * FB;
`endif
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg, ed;
    logic         ew, er;
    logic [1:0]   ea;
    logic [31:0]  edt;
    eg = '0; ed = '0; ew = 1'b0; er = 1'b0; ea = '0; edt = '0;
    if (cyc == m_g_cyc) begin
      eg[m_w] = 1'b1;
      ew = (m_kind == 1);
      er = (m_kind == 2);
      ea = m_addr;
      edt = m_data;
    end else if (cyc == m_g_cyc + 1) begin
      ed[m_w] = 1'b1;
      ea = m_addr;
      edt = m_data;
    end
    chk("bus", {gnt, done, uart_we, uart_re, uart_address, uart_write_data},
        {eg, ed, ew, er, ea, edt});
    if (cyc == m_g_cyc + 1 && m_kind == 2) chk("rdata", rdata, m_rd);
    if (uart_we === 1'b1 && uart_address === TX_DATA) tx_issue.push_back(cyc);
    if (uart_we === 1'b1 && uart_address === ENABLE) en_issue.push_back(cyc);
  endtask

  task automatic step();
    model_arb();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    if (auto_drop) begin
      for (int i = 0; i < N; i++) if (done[i] === 1'b1) req[i] = 1'b0;
    end
    if (rand_rd) uart_read_data = 8'($urandom);
  endtask

  task automatic request(input int i, input logic [1:0] a, input logic [31:0] d,
                         input logic we, input logic re);
    req_address[2*i +: 2]     = a;
    req_write_data[32*i +: 32] = d;
    req_we[i] = we;
    req_re[i] = re;
    req[i]    = 1'b1;
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while (req != '0 && n < budget) begin
      step();
      n++;
    end
    chk("quiet_timeout", 64'(req), 64'(0));
  endtask

  initial begin
    int g_val[$];
    int g_cyc[$];
    int d_cyc[$];
    int re_cnt;
    bit got;
    logic [7:0] rd_seen;

    rst = 1'b1;
    req = '0; req_address = '0; req_write_data = '0; req_we = '0; req_re = '0;
    uart_read_data = 8'h00;
    m_last = N - 1; m_g_cyc = -10; m_next_arb = 0; m_w = 0; m_kind = 0;
    m_addr = '0; m_data = '0; m_rd = '0; m_shadow = 0; m_tx_ok = 0;

    // Reset state
    step();
    step();
    chk("reset_outputs", {gnt, done, uart_we, uart_re, uart_address, uart_write_data}, 64'(0));
    chk("reset_rdata", rdata, 8'h00);
    rst = 1'b0;

    // Round-robin with both requesters holding ENABLE writes
    auto_drop = 1'b0;
    request(0, ENABLE, 32'h0000_0011, 1'b1, 1'b0);
    request(1, ENABLE, 32'h0000_0022, 1'b1, 1'b0);
    for (int s = 0; s < 13; s++) begin
      step();
      if (gnt != '0) begin g_val.push_back(int'(gnt)); g_cyc.push_back(cyc); end
      if (done != '0) d_cyc.push_back(cyc);
    end
    req = '0;
    auto_drop = 1'b1;
    step();
    step();
    chk("rr_count", 64'(g_val.size() >= 4), 64'(1));
    if (g_val.size() >= 4) begin
      chk("rr_g0", 64'(g_val[0]), 64'(1));
      chk("rr_g1", 64'(g_val[1]), 64'(2));
      chk("rr_g2", 64'(g_val[2]), 64'(1));
      chk("rr_g3", 64'(g_val[3]), 64'(2));
      chk("rr_spacing", 64'(g_cyc[1] - g_cyc[0]), 64'(3));
    end
    if (d_cyc.size() >= 1 && g_cyc.size() >= 1)
      chk("rr_done_lat", 64'(d_cyc[0] - g_cyc[0]), 64'(1));

    // Read path
    uart_read_data = 8'hA5;
    request(1, RX_DATA, 32'h0, 1'b0, 1'b1);
    re_cnt = 0; got = 1'b0; rd_seen = '0;
    for (int s = 0; s < 10 && !got; s++) begin
      step();
      if (uart_re === 1'b1) re_cnt++;
      if (done[1] === 1'b1) begin got = 1'b1; rd_seen = rdata; end
    end
    chk("read_done", 64'(got), 64'(1));
    chk("read_re_once", 64'(re_cnt), 64'(1));
    chk("read_data", rd_seen, 8'hA5);
    wait_quiet(10);

    // Guard blocking (or plain round-robin when the guard is compiled out)
    tx_issue.delete(); en_issue.delete();
    request(0, BAUD_DATA, 32'd4, 1'b1, 1'b0);
    wait_quiet(20);
    request(0, TX_DATA, 32'h55, 1'b1, 1'b0);
    wait_quiet(20);
    request(0, TX_DATA, 32'h56, 1'b1, 1'b0);
`ifdef UART_ARB_TX_GUARD_EN
    request(1, ENABLE, 32'h1, 1'b1, 1'b0);
`endif
    wait_quiet(200);
    chk("guard_tx_count", 64'(tx_issue.size()), 64'(2));
`ifdef UART_ARB_TX_GUARD_EN
    if (tx_issue.size() >= 2) chk("guard_tx_gap", 64'(tx_issue[1] - tx_issue[0]), 64'(41));
    chk("guard_en_count", 64'(en_issue.size()), 64'(1));
    if (en_issue.size() >= 1 && tx_issue.size() >= 1)
      chk("guard_en_gap", 64'(en_issue[0] - tx_issue[0]), 64'(3));
`else
    if (tx_issue.size() >= 2) chk("noguard_tx_gap", 64'(tx_issue[1] - tx_issue[0]), 64'(3));
`endif

    // Zero divisor: back-to-back TX_DATA writes
    tx_issue.delete();
    request(0, BAUD_DATA, 32'd0, 1'b1, 1'b0);
    wait_quiet(20);
    request(0, TX_DATA, 32'h41, 1'b1, 1'b0);
    wait_quiet(200);
    request(0, TX_DATA, 32'h42, 1'b1, 1'b0);
    wait_quiet(20);
    chk("zero_tx_count", 64'(tx_issue.size()), 64'(2));
    if (tx_issue.size() >= 2) chk("zero_tx_gap", 64'(tx_issue[1] - tx_issue[0]), 64'(3));

    // Reset in the ISSUE cycle
    request(0, ENABLE, 32'h77, 1'b1, 1'b0);
    got = 1'b0;
    for (int s = 0; s < 10 && !got; s++) begin
      step();
      if (uart_we === 1'b1) got = 1'b1;
    end
    chk("mid_issue_seen", 64'(got), 64'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_outputs", {gnt, done, uart_we, uart_re, uart_address, uart_write_data}, 64'(0));
    chk("mid_rst_rdata", rdata, 8'h00);
    request(1, ENABLE, 32'h88, 1'b1, 1'b0);
    got = 1'b0; rd_seen = '0;
    for (int s = 0; s < 10 && !got; s++) begin
      step();
      if (gnt != '0) begin got = 1'b1; rd_seen = 8'(gnt); end
    end
    chk("post_rst_first", rd_seen, 8'h01);
    wait_quiet(30);

    // Random traffic against the model
    rand_rd = 1'b1;
    for (int s = 0; s < 800; s++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] == 1'b0 && $urandom_range(0, 3) == 0) begin
          logic [1:0] a;
          a = 2'($urandom_range(0, 3));
          request(i, a, (a == BAUD_DATA) ? 32'($urandom_range(0, 3)) : $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
      end
      step();
    end
    wait_quiet(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
